edge_run_encoder: RTL and testbench
===================================

Name: edge_run_encoder

Overview:
- Sits directly downstream of the edge-thinning/Sobel stage and consumes its binary edge stream (pixout, rowout, colout).
- Converts each row's edge pixels into run-length records {row, start_col, length}.
- Buffers the records in a small FIFO and presents them on a valid/ready stream to the stereo feature matcher.
- Removes the per-pixel 25 MHz rate requirement from downstream logic.

Parameters:
- H_ACTIVE, 640, active columns per row (valid col 0..H_ACTIVE-1)
- V_ACTIVE, 480, active rows per frame
- MIN_LEN, 2, runs shorter than this are discarded as noise (1 disables filtering)
- FIFO_DEPTH, 16, record FIFO depth (power of two)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- pix  in  8  edge pixel; bit 7 set = edge (upstream emits 0x00/0xFF)
- row  in  13  row coordinate of pix
- col  in  13  column coordinate of pix
- m_data  out  40  record: [39] eof, [38:26] row, [25:13] start_col, [12:0] length
- m_valid  out  1  record available
- m_ready  in  1  consumer accepts record when m_valid & m_ready at posedge
- fifo_level  out  5  current FIFO occupancy (0..FIFO_DEPTH)
- drop_cnt  out  16  records lost to FIFO full, saturating at 0xFFFF
- overflow  out  1  sticky, set on first drop, cleared only by reset

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - m_valid=0, m_data=0, fifo_level=0, drop_cnt=0, overflow=0.
  - Run state idle; input register cleared.
  - A partial run open at reset is discarded.
- Stage 0: pix/row/col are registered every cycle.
  - A sample is active iff col<H_ACTIVE and row<V_ACTIVE.
  - Inactive samples (including the 8191 wrap produced by upstream col-1/row-1) never open or extend a run; they close any open run.
- Stage 1 run tracker, states IDLE and RUN:
  - IDLE + active edge sample -> RUN; start_col=col, len=1, run_row=row, last_col=col.
  - RUN + active edge with row==run_row and col==last_col+1 -> len+1, last_col=col.
  - RUN + non-edge, inactive sample, row change, or col discontinuity -> close run.
    - If the closing sample is itself an active edge, it opens a new run in the same cycle.
  - RUN + sample at col==H_ACTIVE-1 that is an edge -> extend, then close in the same cycle. Runs never span rows.
- Emit:
  - A closed run with len>=MIN_LEN produces one record.
  - len<MIN_LEN is silently discarded; it is not counted in drop_cnt.
- End of frame (active sample at row==V_ACTIVE-1, col==H_ACTIVE-1):
  - If a run closes on this sample and passes MIN_LEN, its record carries eof=1.
  - Otherwise a marker record is emitted: eof=1, row=V_ACTIVE-1, start_col=0, length=0.
  - At most one FIFO push per cycle, always.
- Latency: record written to FIFO at the posedge after the closing sample is registered. m_valid rises the following cycle (show-ahead FIFO). Total is 2 clocks from input edge to m_valid when the FIFO is empty.
- FIFO:
  - Push when full and no pop -> record dropped, drop_cnt+1 (saturating), overflow=1.
  - Push and pop in the same cycle while full -> accepted, level unchanged.
  - Pop when empty is ignored.
  - m_data holds stable while m_valid=1 and m_ready=0.
- Widths: length is 13 bits, max H_ACTIVE; row/col comparisons are full 13-bit, with no truncation to 10 bits.

Decomposition:
- Package edge_pkg holds:
  - RECORD_W=40
  - field LSB/MSB constants (EOF_BIT, ROW_LSB, START_LSB, LEN_LSB)
  - COORD_W=13
  - the run-record struct typedef
- One sub-module, edge_run_fifo: a parameterised synchronous show-ahead FIFO (width, depth) with push/pop/full/empty/level. The run tracker and drop counters stay in the top.

Test Plan:
- Row 5, edges at cols 10..14 only, m_ready=1 -> one record {eof=0, row=5, start=10, len=5}; m_valid 2 clks after the col-14 sample's successor.
- Edges at cols 630..639 of row 7 -> record {row=7, start=630, len=10}. Col 0 of row 8 edge starts a fresh run; no row-spanning record.
- MIN_LEN=2: isolated edge at col 20 and pair at 30..31 -> only {start=30, len=2} emitted; drop_cnt stays 0.
- Full frame with no edges -> exactly one record {eof=1, row=479, start=0, len=0}. A run ending at (479,639) with start 600 -> single record {eof=1, start=600, len=40}.
- m_ready=0, 20 separated runs -> fifo_level=16, drop_cnt=4, overflow=1, m_data stable. Then m_ready=1 drains 16 records in order.
- Assert rst_n low mid-run at col 50 (run started col 40), release, resume stream -> no record for the partial run; all outputs 0 during reset.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and record layout for the edge run-length encoder.
// A record packs {eof, row, start_col, length} into 40 bits, MSB first.
package edge_pkg;

  localparam int COORD_W   = 13;
  localparam int RECORD_W  = 40;
  localparam int EOF_BIT   = 39;
  localparam int ROW_MSB   = 38;
  localparam int ROW_LSB   = 26;
  localparam int START_MSB = 25;
  localparam int START_LSB = 13;
  localparam int LEN_MSB   = 12;
  localparam int LEN_LSB   = 0;

  typedef struct packed {
    logic               eof;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] start_col;
    logic [COORD_W-1:0] length;
  } run_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/edge_run_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the oldest entry.
// A push while full is accepted only when a pop happens in the same cycle.
module edge_run_fifo
  import edge_pkg::*;
#(
  parameter int WIDTH = RECORD_W,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok_s, pop_ok_s;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop);
    wr_ptr_d  = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; unread entries are never observed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/edge_run_encoder.sv
// Turns the thinned binary edge stream into per-row run-length records,
// buffered in a show-ahead FIFO with drop accounting on overflow.
module edge_run_encoder
  import edge_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_LEN    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   pix,
  input  logic [COORD_W-1:0]           row,
  input  logic [COORD_W-1:0]           col,
  output logic [RECORD_W-1:0]          m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  drop_cnt,
  output logic                         overflow
);

  logic               edge_q;
  logic [COORD_W-1:0] row_q, col_q;
  run_state_t         state_q, state_d;
  logic [COORD_W-1:0] start_q, start_d, len_q, len_d;
  logic [COORD_W-1:0] run_row_q, run_row_d, last_col_q, last_col_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               overflow_q, overflow_d;

  logic               active_s, hit_s, at_last_col_s, eof_s;
  logic               close_s, keep_s, push_s, drop_s;
  logic [COORD_W-1:0] close_len_s;
  run_rec_t           rec_s;
  logic [RECORD_W-1:0] fifo_rdata_s;
  logic               fifo_full_s, fifo_empty_s;
  logic               unused_pix_s;

  // Only the MSB carries edge information; the rest mirror it upstream.
  assign unused_pix_s  = ^pix[6:0];
  assign active_s      = (col_q < COORD_W'(H_ACTIVE)) && (row_q < COORD_W'(V_ACTIVE));
  assign hit_s         = active_s && edge_q;
  assign at_last_col_s = (col_q == COORD_W'(H_ACTIVE - 1));
  assign eof_s         = active_s && at_last_col_s && (row_q == COORD_W'(V_ACTIVE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      edge_q <= pix[7];
      row_q  <= row;
      col_q  <= col;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    len_d       = len_q;
    run_row_d   = run_row_q;
    last_col_d  = last_col_q;
    close_s     = 1'b0;
    close_len_s = len_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d    = ST_RUN;
          start_d    = col_q;
          len_d      = COORD_W'(1);
          run_row_d  = row_q;
          last_col_d = col_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hit_s && (row_q == run_row_q) && (col_q == last_col_q + COORD_W'(1))) begin
          if (at_last_col_s) begin
            // Row end: include this pixel and close so runs never wrap rows.
            close_s     = 1'b1;
            close_len_s = len_q + COORD_W'(1);
            state_d     = ST_IDLE;
          end else begin
            len_d      = len_q + COORD_W'(1);
            last_col_d = col_q;
          end
        end else begin
          close_s = 1'b1;
          if (hit_s) begin
            state_d    = ST_RUN;
            start_d    = col_q;
            len_d      = COORD_W'(1);
            run_row_d  = row_q;
            last_col_d = col_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    keep_s = close_s && (close_len_s >= COORD_W'(MIN_LEN));
    push_s = keep_s || eof_s;
    drop_s = push_s && fifo_full_s && !m_ready;
    if (keep_s) begin
      rec_s = '{eof: eof_s, row: run_row_q, start_col: start_q, length: close_len_s};
    end else begin
      rec_s = '{eof: 1'b1, row: COORD_W'(V_ACTIVE - 1), start_col: '0, length: '0};
    end
    drop_cnt_d = (drop_s && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    overflow_d = overflow_q | drop_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      len_q      <= '0;
      run_row_q  <= '0;
      last_col_q <= '0;
      drop_cnt_q <= 16'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      len_q      <= len_d;
      run_row_q  <= run_row_d;
      last_col_q <= last_col_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  edge_run_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (rec_s),
    .pop   (m_ready),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign m_valid  = !fifo_empty_s;
  assign m_data   = fifo_empty_s ? '0 : fifo_rdata_s;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_run_encoder.sv
// Directed bench for edge_run_encoder: table-driven single-run vectors plus
// hand-written sequences for latency, row ends, end of frame, overflow and reset.
module tb_edge_run_encoder;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix;
  logic [12:0] row, col;
  logic [39:0] m_data;
  logic        m_valid, m_ready;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [39:0] got_q[$];

  edge_run_encoder dut (
    .clk(clk), .rst_n(rst_n), .pix(pix), .row(row), .col(col),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #20 clk = ~clk;

  // Record every accepted transfer; pop happens at the following posedge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) got_q.push_back(m_data);
  end

  typedef struct {
    int          r;
    int          start;
    int          len;
    int          exp_n;
    logic [39:0] exp_rec;
  } vec_t;

  function automatic logic [39:0] mk(input logic eof, input int r, input int s, input int l);
    logic [12:0] rr, ss, ll;
    rr = 13'(r); ss = 13'(s); ll = 13'(l);
    return {eof, rr, ss, ll};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {23'd0, m_valid, m_data, fifo_level, drop_cnt, overflow}, 64'd0);
  endtask

  task automatic drive(input logic e, input int r, input int c);
    pix = e ? 8'hFF : 8'h00;
    row = 13'(r);
    col = 13'(c);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8191, 8191);
  endtask

  task automatic drive_run(input int r, input int start, input int len);
    int lo, hi;
    lo = (start >= 2) ? start - 2 : 0;
    hi = (start + len + 1 > H - 1) ? H - 1 : start + len + 1;
    for (int c = lo; c <= hi; c++) drive((c >= start) && (c < start + len), r, c);
    idle(1);
  endtask

  vec_t vecs[6];
  logic [39:0] first_rec;

  initial begin
    rst_n = 1'b0; m_ready = 1'b1;
    pix = 8'h00; row = 13'h1FFF; col = 13'h1FFF;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset_state");
    rst_n = 1'b1;
    idle(2);

    // Latency: col 15 closes the row-5 run; m_valid 2 clocks after it.
    got_q.delete();
    for (int c = 8; c <= 14; c++) drive(c >= 10, 5, c);
    drive(1'b0, 5, 15);
    chk("lat_not_yet", {63'd0, m_valid}, 64'd0);
    idle(1);
    chk("lat_valid", {63'd0, m_valid}, 64'd1);
    chk("lat_data", {24'd0, m_data}, {24'd0, mk(1'b0, 5, 10, 5)});
    idle(3);
    chk("lat_count", 64'(got_q.size()), 64'd1);

    vecs[0] = '{5,   10,  5,   1, mk(1'b0, 5, 10, 5)};
    vecs[1] = '{7,   630, 10,  1, mk(1'b0, 7, 630, 10)};
    vecs[2] = '{9,   20,  1,   0, 40'd0};
    vecs[3] = '{9,   30,  2,   1, mk(1'b0, 9, 30, 2)};
    vecs[4] = '{100, 0,   640, 1, mk(1'b0, 100, 0, 640)};
    vecs[5] = '{3,   0,   3,   1, mk(1'b0, 3, 0, 3)};
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      drive_run(vecs[i].r, vecs[i].start, vecs[i].len);
      idle(4);
      chk($sformatf("vec%0d_count", i), 64'(got_q.size()), 64'(vecs[i].exp_n));
      if (got_q.size() > 0 && vecs[i].exp_n > 0)
        chk($sformatf("vec%0d_rec", i), {24'd0, got_q[0]}, {24'd0, vecs[i].exp_rec});
    end
    chk("minlen_no_drop", {48'd0, drop_cnt}, 64'd0);

    // Row end closes the run; next row and column jumps open fresh runs.
    got_q.delete();
    for (int c = 634; c <= 639; c++) drive(c >= 636, 7, c);
    for (int c = 0; c <= 3; c++) drive(c <= 2, 8, c);
    for (int c = 198; c <= 203; c++) drive(c >= 200, 11, c);
    drive(1'b1, 12, 204); drive(1'b1, 12, 205); drive(1'b0, 12, 206);
    drive(1'b1, 13, 300); drive(1'b1, 13, 301);
    drive(1'b1, 13, 305); drive(1'b1, 13, 306); drive(1'b0, 13, 307);
    idle(4);
    chk("seq_count", 64'(got_q.size()), 64'd6);
    if (got_q.size() == 6) begin
      chk("seq_row7", {24'd0, got_q[0]}, {24'd0, mk(1'b0, 7, 636, 4)});
      chk("seq_row8", {24'd0, got_q[1]}, {24'd0, mk(1'b0, 8, 0, 3)});
      chk("seq_row11", {24'd0, got_q[2]}, {24'd0, mk(1'b0, 11, 200, 4)});
      chk("seq_row12", {24'd0, got_q[3]}, {24'd0, mk(1'b0, 12, 204, 2)});
      chk("seq_jump_a", {24'd0, got_q[4]}, {24'd0, mk(1'b0, 13, 300, 2)});
      chk("seq_jump_b", {24'd0, got_q[5]}, {24'd0, mk(1'b0, 13, 305, 2)});
    end

    // End of frame: marker when no run closes, eof-flagged run otherwise.
    got_q.delete();
    for (int c = 630; c <= 639; c++) drive(1'b0, V - 1, c);
    idle(4);
    chk("eof_marker_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("eof_marker", {24'd0, got_q[0]}, {24'd0, mk(1'b1, 479, 0, 0)});
    got_q.delete();
    drive_run(V - 1, 600, 40);
    idle(4);
    chk("eof_run_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("eof_run", {24'd0, got_q[0]}, {24'd0, mk(1'b1, 479, 600, 40)});

    // Overflow: 20 records into a 16-deep FIFO with the consumer stalled.
    got_q.delete();
    m_ready = 1'b0;
    first_rec = mk(1'b0, 10, 100, 2);
    for (int i = 0; i < 20; i++) begin
      for (int c = 99; c <= 102; c++) drive((c == 100) || (c == 101), 10 + i, c);
      if (i == 0) begin
        idle(1);
        chk("ovf_head_first", {24'd0, m_data}, {24'd0, first_rec});
      end
    end
    idle(3);
    chk("ovf_level", {59'd0, fifo_level}, 64'd16);
    chk("ovf_drops", {48'd0, drop_cnt}, 64'd4);
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);
    chk("ovf_head_stable", {24'd0, m_valid, m_data}, {24'd1, first_rec});
    m_ready = 1'b1;
    for (int t = 0; t < 40 && got_q.size() < 16; t++) idle(1);
    idle(3);
    chk("drain_count", 64'(got_q.size()), 64'd16);
    if (got_q.size() == 16)
      for (int i = 0; i < 16; i++)
        chk($sformatf("drain_%0d", i), {24'd0, got_q[i]}, {24'd0, mk(1'b0, 10 + i, 100, 2)});
    chk("drain_level", {59'd0, fifo_level}, 64'd0);
    chk("drain_drops_kept", {47'd0, overflow, drop_cnt}, {47'd1, 16'd4});

    // Reset in the middle of a run started at col 40.
    got_q.delete();
    for (int c = 38; c <= 49; c++) drive(c >= 40, 20, c);
    pix = 8'hFF; row = 13'd20; col = 13'd50;
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid_assert");
    @(posedge clk); @(posedge clk); #1;
    chk_reset("rst_mid_hold");
    rst_n = 1'b1;
    for (int c = 51; c <= 60; c++) drive(1'b0, 20, c);
    idle(4);
    chk("rst_partial_dropped", 64'(got_q.size()), 64'd0);
    drive_run(21, 5, 3);
    idle(4);
    chk("rst_recover_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("rst_recover", {24'd0, got_q[0]}, {24'd0, mk(1'b0, 21, 5, 3)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
